// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size
// encodings, the responder FSM states and the request legality check.
package dmem_pkg;

  // RV32I funct3 encodings for loads/stores (size + signedness)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Returns 1 when a request must be rejected: illegal funct3 for the
  // direction, misaligned half/word, or byte address at/after limit.
  // All error causes produce the same response, so they are simply OR-ed.
  function automatic logic dmem_err(input logic        we,
                                    input logic [2:0]  funct3,
                                    input logic [31:0] addr,
                                    input logic [32:0] limit);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = we;     // unsigned forms exist only for loads
      default:          illegal = 1'b1;
    endcase
    case (funct3)
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = (addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    out_of_range = ({1'b0, addr} >= limit);
    return illegal | misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 32-bit storage word: extracts and extends load
// data, and merges store data into the old word leaving other bytes intact.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] new_word_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and half-word out of the stored word
  always_comb begin
    sel_byte = old_word_i[7:0];
    case (lane_i)
      2'd0:    sel_byte = old_word_i[7:0];
      2'd1:    sel_byte = old_word_i[15:8];
      2'd2:    sel_byte = old_word_i[23:16];
      2'd3:    sel_byte = old_word_i[31:24];
      default: sel_byte = old_word_i[7:0];
    endcase
    if (lane_i[1]) begin
      sel_half = old_word_i[31:16];
    end else begin
      sel_half = old_word_i[15:0];
    end
  end

  // Load result: sign- or zero-extend the selected bytes
  always_comb begin
    rdata_o = 32'd0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    rdata_o = {{16{sel_half[15]}}, sel_half};
      F3_W:    rdata_o = old_word_i;
      F3_BU:   rdata_o = {24'd0, sel_byte};
      F3_HU:   rdata_o = {16'd0, sel_half};
      default: rdata_o = 32'd0;
    endcase
  end

  // Store merge: overwrite only the lanes covered by the access size
  always_comb begin
    new_word_o = old_word_i;
    case (funct3_i)
      F3_B: begin
        case (lane_i)
          2'd0:    new_word_o[7:0]   = wdata_i[7:0];
          2'd1:    new_word_o[15:8]  = wdata_i[7:0];
          2'd2:    new_word_o[23:16] = wdata_i[7:0];
          2'd3:    new_word_o[31:24] = wdata_i[7:0];
          default: new_word_o = old_word_i;
        endcase
      end
      F3_H: begin
        if (lane_i[1]) begin
          new_word_o[31:16] = wdata_i[15:0];
        end else begin
          new_word_o[15:0] = wdata_i[15:0];
        end
      end
      F3_W:    new_word_o = wdata_i;
      default: new_word_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store per handshake,
// waits LATENCY cycles, performs the access and holds the response until the
// requester takes it. The storage array is deliberately not reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT_INIT   = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          do_access;
  logic          latch_en;
  logic [31:0]   acc_addr;
  logic          acc_we;
  logic [2:0]    acc_f3;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic [31:0]   old_word;
  logic [31:0]   new_word;
  logic [31:0]   load_rdata;

  // Access operands: with zero latency the access happens in the accept
  // cycle, so the live request is used; otherwise the latched copy
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = req_addr;
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_wdata = req_wdata;
    end else begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_wdata = wdata_q;
    end
    acc_idx  = acc_addr[AW+1:2];
    acc_err  = dmem_err(acc_we, acc_f3, acc_addr, ADDR_LIMIT);
    old_word = mem_q[acc_idx];
  end

  dmem_lane_align u_lane_align (
    .old_word_i (old_word),
    .wdata_i    (acc_wdata),
    .funct3_i   (acc_f3),
    .lane_i     (acc_addr[1:0]),
    .new_word_o (new_word),
    .rdata_o    (load_rdata)
  );

  // Next-state, wait counter and access strobe for IDLE -> BUSY -> RESP
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          latch_en = 1'b1;
          cnt_d    = LAT_INIT;
          if (LATENCY == 0) begin
            do_access = 1'b1;
            state_d   = S_RESP;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = S_RESP;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Request latch, response capture and registered handshake outputs
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (latch_en) begin
      addr_d  = req_addr;
      we_d    = req_we;
      f3_d    = req_funct3;
      wdata_d = req_wdata;
    end else begin
      addr_d  = addr_q;
    end
    if (do_access) begin
      err_d = acc_err;
      if (acc_err || acc_we) begin
        rdata_d = 32'd0;
      end else begin
        rdata_d = load_rdata;
      end
    end else begin
      err_d = err_q;
    end
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // Control and response registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Storage write: only error-free stores, and never on a reset edge so an
  // aborted store is dropped
  always_ff @(posedge clk) begin
    if (!reset && do_access && acc_we && !acc_err) begin
      mem_q[acc_idx] <= new_word;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 and one LATENCY=0
// instance, expected responses queued at request time and popped on response.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid2, req_valid0;
  logic        rsp_ready2, rsp_ready0;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        req_ready2, req_ready0;
  logic        rsp_valid2, rsp_valid0;
  logic [31:0] rsp_rdata2, rsp_rdata0;
  logic        rsp_err2, rsp_err0;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic obs_valid(input bit sel);
    return sel ? rsp_valid0 : rsp_valid2;
  endfunction
  function automatic logic obs_ready(input bit sel);
    return sel ? req_ready0 : req_ready2;
  endfunction
  function automatic logic [31:0] obs_rdata(input bit sel);
    return sel ? rsp_rdata0 : rsp_rdata2;
  endfunction
  function automatic logic obs_err(input bit sel);
    return sel ? rsp_err0 : rsp_err2;
  endfunction

  // sel=0 -> LATENCY=2 instance, sel=1 -> LATENCY=0 instance
  task automatic do_req(input bit sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int hold);
    int          lat;
    int          n;
    logic [31:0] held;
    exp_t        e;
    lat = sel ? 0 : 2;
    @(negedge clk);
    req_addr   = addr;
    req_we     = we;
    req_funct3 = f3;
    req_wdata  = wdata;
    if (sel) req_valid0 = 1'b1;
    else     req_valid2 = 1'b1;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    check_eq("req_ready_idle", 32'(obs_ready(sel)), 32'd1);
    @(posedge clk);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      req_valid0 = 1'b0;
      req_valid2 = 1'b0;
      n++;
      if (obs_valid(sel)) break;
    end
    check_eq("rsp_latency", 32'(n), 32'(lat + 1));
    held = obs_rdata(sel);
    for (int i = 0; i < hold; i++) begin
      check_eq("bp_valid", 32'(obs_valid(sel)), 32'd1);
      check_eq("bp_rdata_stable", obs_rdata(sel), held);
      check_eq("bp_req_ready", 32'(obs_ready(sel)), 32'd0);
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check_eq("rsp_rdata", obs_rdata(sel), e.rdata);
    check_eq("rsp_err", 32'(obs_err(sel)), 32'(e.err));
    if (sel) rsp_ready0 = 1'b1;
    else     rsp_ready2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready0 = 1'b0;
    rsp_ready2 = 1'b0;
    check_eq("post_rsp_ready", 32'(obs_ready(sel)), 32'd1);
    check_eq("post_rsp_valid", 32'(obs_valid(sel)), 32'd0);
  endtask

  // Watchdog so the run always ends even if the DUT stalls forever
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid2 = 1'b0;
    req_valid0 = 1'b0;
    rsp_ready2 = 1'b0;
    rsp_ready0 = 1'b0;
    req_addr   = 32'd0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready2", 32'(req_ready2), 32'd1);
    check_eq("rst_rsp_valid2", 32'(rsp_valid2), 32'd0);
    check_eq("rst_rdata2", rsp_rdata2, 32'd0);
    check_eq("rst_err2", 32'(rsp_err2), 32'd0);
    check_eq("rst_req_ready0", 32'(req_ready0), 32'd1);
    check_eq("rst_rsp_valid0", 32'(rsp_valid0), 32'd0);
    reset = 1'b0;

    // LATENCY=2: word store/load and sub-word accesses
    do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 0);
    do_req(1'b0, 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 0);
    do_req(1'b0, 1'b1, 3'd0, 32'h11, 32'hFFFFFF7F, 32'd0, 1'b0, 0);
    do_req(1'b0, 1'b0, 3'd0, 32'h11, 32'd0, 32'h0000007F, 1'b0, 0);
    do_req(1'b0, 1'b0, 3'd4, 32'h13, 32'd0, 32'h000000DE, 1'b0, 0);
    do_req(1'b0, 1'b0, 3'd1, 32'h12, 32'd0, 32'hFFFFDEAD, 1'b0, 0);
    do_req(1'b0, 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEAD7FEF, 1'b0, 0);

    // Errors: misaligned, out of range, illegal funct3 (incl. store-unsigned)
    do_req(1'b0, 1'b0, 3'd2, 32'h12, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b0, 1'b0, 3'd1, 32'h01, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b0, 1'b1, 3'd2, 32'(4 * DEPTH), 32'h11111111, 32'd0, 1'b1, 0);
    do_req(1'b0, 1'b0, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b0, 1'b1, 3'd4, 32'h10, 32'h00000055, 32'd0, 1'b1, 0);
    do_req(1'b0, 1'b1, 3'd1, 32'h11, 32'h00005555, 32'd0, 1'b1, 0);

    // Memory unchanged, read back under 5 cycles of backpressure
    do_req(1'b0, 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEAD7FEF, 1'b0, 5);

    // LATENCY=0 instance: same-cycle access
    do_req(1'b1, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 32'd0, 1'b0, 0);
    do_req(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 32'hCAFEF00D, 1'b0, 0);
    do_req(1'b1, 1'b0, 3'd5, 32'h42, 32'd0, 32'h0000CAFE, 1'b0, 0);
    do_req(1'b1, 1'b1, 3'd1, 32'h40, 32'hABCD1234, 32'd0, 1'b0, 0);
    do_req(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 32'hCAFE1234, 1'b0, 0);
    do_req(1'b1, 1'b0, 3'd0, 32'h43, 32'd0, 32'hFFFFFFCA, 1'b0, 2);

    // Reset during BUSY of a store drops the store
    do_req(1'b0, 1'b1, 3'd2, 32'h20, 32'hA5A50F0F, 32'd0, 1'b0, 0);
    @(negedge clk);
    req_addr   = 32'h20;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_wdata  = 32'h12345678;
    req_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid2 = 1'b0;
    check_eq("busy_rsp_valid", 32'(rsp_valid2), 32'd0);
    check_eq("busy_req_ready", 32'(req_ready2), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_rsp_valid", 32'(rsp_valid2), 32'd0);
    check_eq("abort_req_ready", 32'(req_ready2), 32'd1);
    do_req(1'b0, 1'b0, 3'd2, 32'h20, 32'd0, 32'hA5A50F0F, 1'b0, 0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
